// File: rtl/register_bank_pkg.sv
// Shared defaults for the general-purpose register bank and the helper that
// locates the program-counter register; the control unit decoder uses it too.
package register_bank_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_ADDR_W   = 4;

    // The PC is always the highest-numbered register in the bank.
    function automatic int pc_index(input int num_regs);
        return num_regs - 1;
    endfunction

endpackage

// File: rtl/register_bank_reg_cell.sv
// One bank register: async clear, load enable and optional +1 increment.
// Load has priority over increment. nxt exposes the value the next edge will store.
module reg_cell
    import register_bank_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter bit INC_EN = 1'b0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             incr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nxt
);

    logic [WIDTH-1:0] val_q;
    logic [WIDTH-1:0] val_d;

    always_comb begin
        val_d = val_q;
        if (load) begin
            val_d = din;
        end else if (INC_EN && incr) begin
            val_d = val_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign q   = val_q;
    assign nxt = val_d;

endmodule

// File: rtl/register_bank.sv
// General-purpose register bank: one bus write port, two registered read ports
// that see the post-edge state (write-forwarding), and a PC with auto-increment.
module register_bank
    import register_bank_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int PC_EN    = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rin,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  buswires,
    input  logic              incr_pc,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_a,
    output logic [WIDTH-1:0]  rdata_b,
    output logic [WIDTH-1:0]  pc_out,
    output logic              addr_err
);

    localparam int PC_IDX  = pc_index(NUM_REGS);
    localparam int ADDR_SP = 2 ** ADDR_W;

    // Arrays span the whole index space; unimplemented slots read as zero,
    // which gives out-of-range reads their 0 result without extra muxing.
    logic [WIDTH-1:0] cell_q   [ADDR_SP];
    logic [WIDTH-1:0] cell_nxt [ADDR_SP];

    for (genvar i = 0; i < ADDR_SP; i++) begin : g_cell
        if (i < NUM_REGS) begin : g_impl
            reg_cell #(
                .WIDTH  (WIDTH),
                .INC_EN ((PC_EN != 0) && (i == PC_IDX))
            ) u_cell (
                .clk    (clk),
                .resetn (resetn),
                .load   (rin && (waddr == ADDR_W'(i))),
                .incr   (incr_pc),
                .din    (buswires),
                .q      (cell_q[i]),
                .nxt    (cell_nxt[i])
            );
        end else begin : g_pad
            assign cell_q[i]   = '0;
            assign cell_nxt[i] = '0;
        end
    end

    logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
    logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
    logic             addr_err_q, addr_err_d;

    // Reading the next-state value folds in write-forwarding and PC increment.
    always_comb begin
        rdata_a_d  = cell_nxt[raddr_a];
        rdata_b_d  = cell_nxt[raddr_b];
        addr_err_d = (rin && (int'(waddr) >= NUM_REGS))
                   || (int'(raddr_a) >= NUM_REGS)
                   || (int'(raddr_b) >= NUM_REGS);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;
    assign addr_err = addr_err_q;
    assign pc_out   = cell_q[PC_IDX];

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: four parameterisations share one stimulus stream and
// are compared against an array-based model of the bank after every edge.
module tb_register_bank;

    localparam int ND = 4;
    localparam int CFG_W  [ND] = '{16, 16, 8, 32};
    localparam int CFG_N  [ND] = '{8, 6, 4, 16};
    localparam int CFG_PC [ND] = '{1, 1, 0, 0};

    logic        clk;
    logic        resetn;
    logic        rin;
    logic        incr;
    logic [3:0]  waddr;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [31:0] bus;

    logic [15:0] r0a, r0b, p0;
    logic [15:0] r1a, r1b, p1;
    logic [7:0]  r2a, r2b, p2;
    logic [31:0] r3a, r3b, p3;
    logic        e0, e1, e2, e3;

    logic [31:0] o_a [ND];
    logic [31:0] o_b [ND];
    logic [31:0] o_pc[ND];
    logic        o_err[ND];

    logic [31:0] mdl [ND][16];
    logic [31:0] e_a [ND];
    logic [31:0] e_b [ND];
    logic        e_err[ND];

    int ncmp;
    int nfail;

    register_bank #(.WIDTH(16), .NUM_REGS(8), .ADDR_W(4), .PC_EN(1)) u_d0 (
        .clk(clk), .resetn(resetn), .rin(rin), .waddr(waddr), .buswires(bus[15:0]),
        .incr_pc(incr), .raddr_a(ra), .raddr_b(rb),
        .rdata_a(r0a), .rdata_b(r0b), .pc_out(p0), .addr_err(e0));

    register_bank #(.WIDTH(16), .NUM_REGS(6), .ADDR_W(4), .PC_EN(1)) u_d1 (
        .clk(clk), .resetn(resetn), .rin(rin), .waddr(waddr), .buswires(bus[15:0]),
        .incr_pc(incr), .raddr_a(ra), .raddr_b(rb),
        .rdata_a(r1a), .rdata_b(r1b), .pc_out(p1), .addr_err(e1));

    register_bank #(.WIDTH(8), .NUM_REGS(4), .ADDR_W(4), .PC_EN(0)) u_d2 (
        .clk(clk), .resetn(resetn), .rin(rin), .waddr(waddr), .buswires(bus[7:0]),
        .incr_pc(incr), .raddr_a(ra), .raddr_b(rb),
        .rdata_a(r2a), .rdata_b(r2b), .pc_out(p2), .addr_err(e2));

    register_bank #(.WIDTH(32), .NUM_REGS(16), .ADDR_W(4), .PC_EN(0)) u_d3 (
        .clk(clk), .resetn(resetn), .rin(rin), .waddr(waddr), .buswires(bus),
        .incr_pc(incr), .raddr_a(ra), .raddr_b(rb),
        .rdata_a(r3a), .rdata_b(r3b), .pc_out(p3), .addr_err(e3));

    assign o_a[0] = 32'(r0a);  assign o_b[0] = 32'(r0b);  assign o_pc[0] = 32'(p0);  assign o_err[0] = e0;
    assign o_a[1] = 32'(r1a);  assign o_b[1] = 32'(r1b);  assign o_pc[1] = 32'(p1);  assign o_err[1] = e1;
    assign o_a[2] = 32'(r2a);  assign o_b[2] = 32'(r2b);  assign o_pc[2] = 32'(p2);  assign o_err[2] = e2;
    assign o_a[3] = r3a;       assign o_b[3] = r3b;       assign o_pc[3] = p3;       assign o_err[3] = e3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < ND; d++) begin
            for (int r = 0; r < 16; r++) mdl[d][r] = '0;
            e_a[d]   = '0;
            e_b[d]   = '0;
            e_err[d] = 1'b0;
        end
    endtask

    // Bank behaviour for one clock edge, applied to each configuration.
    task automatic model_step();
        for (int d = 0; d < ND; d++) begin
            int n;
            logic [31:0] mask;
            logic [31:0] nxt [16];
            n    = CFG_N[d];
            mask = (CFG_W[d] == 32) ? 32'hFFFF_FFFF : ((32'd1 << CFG_W[d]) - 32'd1);
            for (int r = 0; r < 16; r++) nxt[r] = mdl[d][r];
            if (CFG_PC[d] != 0 && incr) nxt[n-1] = (mdl[d][n-1] + 32'd1) & mask;
            if (rin && int'(waddr) < n) nxt[waddr] = bus & mask;
            e_a[d]   = (int'(ra) < n) ? nxt[ra] : 32'd0;
            e_b[d]   = (int'(rb) < n) ? nxt[rb] : 32'd0;
            e_err[d] = (rin && int'(waddr) >= n) || (int'(ra) >= n) || (int'(rb) >= n);
            for (int r = 0; r < 16; r++) mdl[d][r] = nxt[r];
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < ND; d++) begin
            check($sformatf("d%0d_rdata_a", d), o_a[d], e_a[d]);
            check($sformatf("d%0d_rdata_b", d), o_b[d], e_b[d]);
            check($sformatf("d%0d_pc_out", d), o_pc[d], mdl[d][CFG_N[d]-1]);
            check($sformatf("d%0d_addr_err", d), 32'(o_err[d]), 32'(e_err[d]));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic r, input logic [3:0] wa, input logic [31:0] b,
                         input logic inc, input logic [3:0] a, input logic [3:0] bb);
        rin = r; waddr = wa; bus = b; incr = inc; ra = a; rb = bb;
    endtask

    initial begin
        ncmp  = 0;
        nfail = 0;
        resetn = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
        model_clear();
        #3;
        check_all();
        @(negedge clk);
        resetn = 1'b1;

        // write and read back with forwarding, then hold
        drive(1'b1, 4'd3, 32'h0000_A5A5, 1'b0, 4'd3, 4'd0);
        cycle();
        check("t2_fwd_a", o_a[0], 32'h0000_A5A5);
        drive(1'b0, 4'd3, 32'h0000_5A5A, 1'b0, 4'd3, 4'd3);
        for (int k = 0; k < 10; k++) cycle();
        check("t2_hold_a", o_a[0], 32'h0000_A5A5);
        check("t2_hold_b", o_b[0], 32'h0000_A5A5);

        // both ports forward the same in-flight write
        drive(1'b1, 4'd2, 32'h0000_1234, 1'b0, 4'd2, 4'd2);
        cycle();
        check("t3_fwd_a", o_a[0], 32'h0000_1234);
        check("t3_fwd_b", o_b[0], 32'h0000_1234);

        // PC wrap, then write beats increment
        drive(1'b1, 4'd7, 32'h0000_FFFF, 1'b0, 4'd7, 4'd0);
        cycle();
        check("t4_pc_load", o_pc[0], 32'h0000_FFFF);
        drive(1'b0, 4'd7, 32'h0000_0000, 1'b1, 4'd7, 4'd0);
        cycle();
        check("t4_pc_wrap", o_pc[0], 32'h0000_0000);
        check("t4_rd_wrap", o_a[0], 32'h0000_0000);
        drive(1'b1, 4'd7, 32'h0000_0040, 1'b1, 4'd7, 4'd0);
        cycle();
        check("t4_pc_prio", o_pc[0], 32'h0000_0040);
        drive(1'b1, 4'd1, 32'h0000_0077, 1'b1, 4'd1, 4'd7);
        cycle();
        check("t4_both_w", o_a[0], 32'h0000_0077);
        check("t4_both_pc", o_pc[0], 32'h0000_0041);

        // out-of-range on the 6-register bank
        drive(1'b1, 4'd7, 32'h0000_BEEF, 1'b0, 4'd0, 4'd0);
        cycle();
        check("t5_werr", 32'(o_err[1]), 32'd1);
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
        cycle();
        check("t5_werr_clr", 32'(o_err[1]), 32'd0);
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd6);
        cycle();
        check("t5_rerr", 32'(o_err[1]), 32'd1);
        check("t5_rzero", o_b[1], 32'd0);

        // async reset mid-cycle, then release mid-cycle with a write pending
        #2;
        resetn = 1'b0;
        #1;
        model_clear();
        check_all();
        #1;
        resetn = 1'b1;
        drive(1'b1, 4'd1, 32'h1357_9BDF, 1'b1, 4'd1, 4'd1);
        cycle();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd1, 4'd0);
        cycle();
        check("t1_no_loss", o_a[0], 32'h0000_9BDF);

        // randomized traffic across all configurations
        for (int k = 0; k < 400; k++) begin
            rin   = 1'($urandom_range(0, 1));
            waddr = 4'($urandom_range(0, 15));
            bus   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            incr  = 1'($urandom_range(0, 1));
            ra    = 4'($urandom_range(0, 15));
            rb    = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
